tm_slave_tag_return: RTL and testbench

//  Slave-side credit shell. It sits between the slave's dpkt/pkt pair and the slave module, on the far side of the NoC from a tagged master shell.
//  - Captures the tag carried by each accepted request in an in-order tag FIFO.
//  - Forwards the request payload to the slave module.
//  - Re-attaches the oldest captured tag to each response the module produces.
//  - Buffers tagged responses in a small FIFO until the pkt accepts them.

---
 rtl/tm_slave_tag_return.sv | 164 ++++++++++++++++
 tb/tb_tm_slave_tag_return.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_slave_tag_return.sv
// ---------------------------------------------------------------------------
// tm_slave_tag_return
//
// Slave-side credit shell. It sits between the NoC request/response ports
// and a slave module that knows nothing about tags. Each accepted request
// leaves its tag in an in-order tag FIFO. Each response the module produces
// takes the oldest tag from that FIFO. The tagged response then waits in a
// small first-word-fall-through FIFO until the packetiser accepts it. The
// master on the far side uses the tag to reorder responses that come back
// from several slaves.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_in/tag/data     request from dpkt
//   req_ready_out             ready to dpkt (module ready and tag FIFO not full)
//   req_valid_out/data_out    request forwarded to the slave module
//   req_ready_in              slave module ready for a request
//   resp_valid_in/data_in     response from the slave module
//   resp_ready_out            response FIFO has room
//   resp_valid_out/tag/data   head of the response FIFO, to pkt
//   resp_ready_in             pkt ready
//   outstanding_count         number of tags currently held
//   orphan_err                sticky: a response arrived while no tag was held
// ---------------------------------------------------------------------------
module tm_slave_tag_return #(
    parameter int WIDTH_TAG       = 8,
    parameter int WIDTH_DATA_IN   = 36,
    parameter int WIDTH_DATA_OUT  = 36,
    parameter int MAX_OUTSTANDING = 8,
    parameter int RESP_DEPTH      = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     req_valid_in,
    input  logic [WIDTH_TAG-1:0]                     req_tag_in,
    input  logic [WIDTH_DATA_IN-1:0]                 req_data_in,
    output logic                                     req_ready_out,
    output logic                                     req_valid_out,
    output logic [WIDTH_DATA_IN-1:0]                 req_data_out,
    input  logic                                     req_ready_in,
    input  logic                                     resp_valid_in,
    input  logic [WIDTH_DATA_OUT-1:0]                resp_data_in,
    output logic                                     resp_ready_out,
    output logic                                     resp_valid_out,
    output logic [WIDTH_TAG-1:0]                     resp_tag_out,
    output logic [WIDTH_DATA_OUT-1:0]                resp_data_out,
    input  logic                                     resp_ready_in,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_count,
    output logic                                     orphan_err
);

    localparam int TAG_AW  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int RESP_AW = $clog2(RESP_DEPTH);

    // The depth is a power of two, so CNT_W == TAG_AW + 1. The tag pointers
    // therefore carry the extra wrap bit, and their difference is the
    // occupancy directly.
    localparam logic [CNT_W-1:0] TAG_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] TAG_ONE = CNT_W'(1);
    localparam logic [RESP_AW:0] RESP_ONE = (RESP_AW + 1)'(1);

    // ---------------------------------------------------------------- storage
    logic [WIDTH_TAG-1:0]      tag_mem_q       [MAX_OUTSTANDING];
    logic [WIDTH_TAG-1:0]      resp_tag_mem_q  [RESP_DEPTH];
    logic [WIDTH_DATA_OUT-1:0] resp_data_mem_q [RESP_DEPTH];

    logic [CNT_W-1:0] tag_wr_ptr_q, tag_wr_ptr_d;
    logic [CNT_W-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
    logic [RESP_AW:0] resp_wr_ptr_q, resp_wr_ptr_d;
    logic [RESP_AW:0] resp_rd_ptr_q, resp_rd_ptr_d;
    logic             orphan_q, orphan_d;

    // ------------------------------------------------------------ status
    logic [CNT_W-1:0]     tag_count;
    logic                 tag_full, tag_empty;
    logic                 resp_full, resp_empty;
    logic                 req_push, resp_accept, tag_pop, resp_pop;
    logic [WIDTH_TAG-1:0] head_tag;

    assign tag_count = tag_wr_ptr_q - tag_rd_ptr_q;
    assign tag_full  = (tag_count == TAG_MAX);
    assign tag_empty = (tag_count == '0);

    assign resp_empty = (resp_wr_ptr_q == resp_rd_ptr_q);
    assign resp_full  = (resp_wr_ptr_q[RESP_AW] != resp_rd_ptr_q[RESP_AW]) &&
                        (resp_wr_ptr_q[RESP_AW-1:0] == resp_rd_ptr_q[RESP_AW-1:0]);

    // ------------------------------------------------------- request path
    // Pure combinational pass-through. A full tag FIFO blocks both
    // directions, so the module never sees a request whose tag was dropped.
    assign req_valid_out = req_valid_in & ~tag_full;
    assign req_data_out  = req_data_in;
    assign req_ready_out = req_ready_in & ~tag_full;
    assign req_push      = req_valid_in & req_ready_out;

    // ------------------------------------------------------ response path
    // No bypass on a full response FIFO. Accept depends only on local state,
    // which keeps resp_ready_out free of a path from resp_ready_in.
    assign resp_ready_out = ~resp_full;
    assign resp_accept    = resp_valid_in & resp_ready_out;
    assign tag_pop        = resp_accept & ~tag_empty;
    assign resp_pop       = ~resp_empty & resp_ready_in;

    // An orphan response gets tag 0. The memory contents are stale when the
    // FIFO is empty, so they must not leak out as a tag.
    assign head_tag = tag_empty ? '0 : tag_mem_q[tag_rd_ptr_q[TAG_AW-1:0]];

    assign resp_valid_out    = ~resp_empty;
    assign resp_tag_out      = resp_tag_mem_q[resp_rd_ptr_q[RESP_AW-1:0]];
    assign resp_data_out     = resp_data_mem_q[resp_rd_ptr_q[RESP_AW-1:0]];
    assign outstanding_count = tag_count;
    assign orphan_err        = orphan_q;

    // ------------------------------------------------------ next state
    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        tag_wr_ptr_d  = tag_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;
        resp_wr_ptr_d = resp_wr_ptr_q;
        resp_rd_ptr_d = resp_rd_ptr_q;
        orphan_d      = orphan_q;

        if (req_push)    tag_wr_ptr_d  = tag_wr_ptr_q + TAG_ONE;
        if (tag_pop)     tag_rd_ptr_d  = tag_rd_ptr_q + TAG_ONE;
        if (resp_accept) resp_wr_ptr_d = resp_wr_ptr_q + RESP_ONE;
        if (resp_pop)    resp_rd_ptr_d = resp_rd_ptr_q + RESP_ONE;
        if (resp_accept && tag_empty) orphan_d = 1'b1;
    end

    // NOTE: state is updated with non-blocking assignments. All registers
    // then sample the same pre-edge values, and this reset is sampled on the
    // clock edge rather than acting asynchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
            resp_wr_ptr_q <= '0;
            resp_rd_ptr_q <= '0;
            orphan_q      <= 1'b0;
        end else begin
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
            resp_wr_ptr_q <= resp_wr_ptr_d;
            resp_rd_ptr_q <= resp_rd_ptr_d;
            orphan_q      <= orphan_d;
        end
    end

    // NOTE: the FIFO storage arrays are deliberately not reset. Emptiness is
    // carried entirely by the pointers, and entries are never read before
    // they have been written.
    always_ff @(posedge clk) begin
        if (req_push) begin
            tag_mem_q[tag_wr_ptr_q[TAG_AW-1:0]] <= req_tag_in;
        end
        if (resp_accept) begin
            resp_tag_mem_q[resp_wr_ptr_q[RESP_AW-1:0]]  <= head_tag;
            resp_data_mem_q[resp_wr_ptr_q[RESP_AW-1:0]] <= resp_data_in;
        end
    end

endmodule

// File: tb/tb_tm_slave_tag_return.sv
// ---------------------------------------------------------------------------
// tb_tm_slave_tag_return
//
// Directed bench for tm_slave_tag_return with default parameters.
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// 1-2 units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_tm_slave_tag_return;

    logic        clk;
    logic        rst;
    logic        req_valid_in;
    logic [7:0]  req_tag_in;
    logic [35:0] req_data_in;
    logic        req_ready_out;
    logic        req_valid_out;
    logic [35:0] req_data_out;
    logic        req_ready_in;
    logic        resp_valid_in;
    logic [35:0] resp_data_in;
    logic        resp_ready_out;
    logic        resp_valid_out;
    logic [7:0]  resp_tag_out;
    logic [35:0] resp_data_out;
    logic        resp_ready_in;
    logic [3:0]  outstanding_count;
    logic        orphan_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    tm_slave_tag_return dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_in      (req_valid_in),
        .req_tag_in        (req_tag_in),
        .req_data_in       (req_data_in),
        .req_ready_out     (req_ready_out),
        .req_valid_out     (req_valid_out),
        .req_data_out      (req_data_out),
        .req_ready_in      (req_ready_in),
        .resp_valid_in     (resp_valid_in),
        .resp_data_in      (resp_data_in),
        .resp_ready_out    (resp_ready_out),
        .resp_valid_out    (resp_valid_out),
        .resp_tag_out      (resp_tag_out),
        .resp_data_out     (resp_data_out),
        .resp_ready_in     (resp_ready_in),
        .outstanding_count (outstanding_count),
        .orphan_err        (orphan_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // ---------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid_in  = 1'b0;
        req_tag_in    = '0;
        req_data_in   = '0;
        req_ready_in  = 1'b1;
        resp_valid_in = 1'b0;
        resp_data_in  = '0;
        resp_ready_in = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_req(input logic [7:0] tag);
        req_valid_in = 1'b1;
        req_tag_in   = tag;
        req_data_in  = {28'h0, tag};
        tick();
        req_valid_in = 1'b0;
    endtask

    // ---------------------------------------------------------- scenarios
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        #1;
        total_cnt++; if (outstanding_count !== 4'd0) $display("FAIL rst_count got %0d exp 0", outstanding_count); else pass_cnt++;
        total_cnt++; if (resp_valid_out !== 1'b0) $display("FAIL rst_resp_valid got %b exp 0", resp_valid_out); else pass_cnt++;
        total_cnt++; if (resp_ready_out !== 1'b1) $display("FAIL rst_resp_ready got %b exp 1", resp_ready_out); else pass_cnt++;
        total_cnt++; if (orphan_err !== 1'b0) $display("FAIL rst_orphan got %b exp 0", orphan_err); else pass_cnt++;
        total_cnt++; if (req_ready_out !== 1'b1) $display("FAIL rst_req_ready_hi got %b exp 1", req_ready_out); else pass_cnt++;
        req_ready_in = 1'b0;
        #1;
        total_cnt++; if (req_ready_out !== 1'b0) $display("FAIL rst_req_ready_lo got %b exp 0", req_ready_out); else pass_cnt++;
        tick();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_in_order();
        logic [7:0]  exp_tag [3] = '{8'h05, 8'h06, 8'h07};
        logic [35:0] dat     [3] = '{36'h0_0000_000A, 36'h0_0000_000B, 36'h0_0000_000C};
        do_reset();
        req_valid_in = 1'b1;
        req_tag_in   = 8'h05;
        req_data_in  = 36'h9_1234_5678;
        #1;
        total_cnt++; if (req_valid_out !== 1'b1) $display("FAIL io_req_valid got %b exp 1", req_valid_out); else pass_cnt++;
        total_cnt++; if (req_data_out !== 36'h9_1234_5678) $display("FAIL io_req_data got %h exp 912345678", req_data_out); else pass_cnt++;
        tick();
        push_req(8'h06);
        push_req(8'h07);
        total_cnt++; if (outstanding_count !== 4'd3) $display("FAIL io_count3 got %0d exp 3", outstanding_count); else pass_cnt++;
        resp_valid_in = 1'b1;
        resp_data_in  = dat[0];
        #1;
        total_cnt++; if (resp_valid_out !== 1'b0) $display("FAIL io_pre_valid got %b exp 0", resp_valid_out); else pass_cnt++;
        tick();
        for (int i = 1; i <= 3; i++) begin
            if (i < 3) resp_data_in = dat[i];
            else       resp_valid_in = 1'b0;
            #1;
            total_cnt++; if (resp_valid_out !== 1'b1) $display("FAIL io_valid%0d got %b exp 1", i, resp_valid_out); else pass_cnt++;
            total_cnt++; if (resp_tag_out !== exp_tag[i-1]) $display("FAIL io_tag%0d got %h exp %h", i, resp_tag_out, exp_tag[i-1]); else pass_cnt++;
            total_cnt++; if (resp_data_out !== dat[i-1]) $display("FAIL io_data%0d got %h exp %h", i, resp_data_out, dat[i-1]); else pass_cnt++;
            tick();
        end
        total_cnt++; if (resp_valid_out !== 1'b0) $display("FAIL io_drained got %b exp 0", resp_valid_out); else pass_cnt++;
        total_cnt++; if (outstanding_count !== 4'd0) $display("FAIL io_count0 got %0d exp 0", outstanding_count); else pass_cnt++;
    endtask

    task automatic test_tag_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            req_valid_in = 1'b1;
            req_tag_in   = 8'(8'h10 + i);
            #1;
            total_cnt++; if (req_ready_out !== 1'b1) $display("FAIL tf_ready%0d got %b exp 1", i, req_ready_out); else pass_cnt++;
            tick();
        end
        req_tag_in = 8'hEE;
        #1;
        total_cnt++; if (outstanding_count !== 4'd8) $display("FAIL tf_count8 got %0d exp 8", outstanding_count); else pass_cnt++;
        total_cnt++; if (req_ready_out !== 1'b0) $display("FAIL tf_ready_full got %b exp 0", req_ready_out); else pass_cnt++;
        total_cnt++; if (req_valid_out !== 1'b0) $display("FAIL tf_valid_full got %b exp 0", req_valid_out); else pass_cnt++;
        tick();
        total_cnt++; if (outstanding_count !== 4'd8) $display("FAIL tf_count_hold got %0d exp 8", outstanding_count); else pass_cnt++;
        req_valid_in  = 1'b0;
        resp_valid_in = 1'b1;
        resp_data_in  = 36'h1;
        tick();
        resp_valid_in = 1'b0;
        #1;
        total_cnt++; if (req_ready_out !== 1'b1) $display("FAIL tf_reopen got %b exp 1", req_ready_out); else pass_cnt++;
        total_cnt++; if (outstanding_count !== 4'd7) $display("FAIL tf_count7 got %0d exp 7", outstanding_count); else pass_cnt++;
        total_cnt++; if (resp_tag_out !== 8'h10) $display("FAIL tf_tag got %h exp 10", resp_tag_out); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 5; i++) push_req(8'(8'h20 + i));
        resp_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            resp_valid_in = 1'b1;
            resp_data_in  = 36'(36'h100 + i);
            #1;
            total_cnt++; if (resp_ready_out !== 1'(i < 4)) $display("FAIL bp_ready%0d got %b exp %b", i, resp_ready_out, 1'(i < 4)); else pass_cnt++;
            if (i >= 1) begin
                total_cnt++; if (resp_tag_out !== 8'h20 || resp_data_out !== 36'h100) $display("FAIL bp_head%0d got %h/%h exp 20/100", i, resp_tag_out, resp_data_out); else pass_cnt++;
            end
            tick();
        end
        resp_valid_in = 1'b0;
        #1;
        total_cnt++; if (outstanding_count !== 4'd1) $display("FAIL bp_count1 got %0d exp 1", outstanding_count); else pass_cnt++;
        resp_ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total_cnt++; if (resp_valid_out !== 1'b1 || resp_tag_out !== 8'(8'h20 + i) || resp_data_out !== 36'(36'h100 + i))
                $display("FAIL bp_drain%0d got %b/%h/%h exp 1/%h/%h", i, resp_valid_out, resp_tag_out, resp_data_out, 8'(8'h20 + i), 36'(36'h100 + i));
            else pass_cnt++;
            tick();
        end
        total_cnt++; if (resp_valid_out !== 1'b0) $display("FAIL bp_empty got %b exp 0", resp_valid_out); else pass_cnt++;
        total_cnt++; if (outstanding_count !== 4'd1) $display("FAIL bp_count_end got %0d exp 1", outstanding_count); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        push_req(8'h31);
        push_req(8'h32);
        push_req(8'h33);
        req_valid_in  = 1'b1;
        req_tag_in    = 8'h34;
        resp_valid_in = 1'b1;
        resp_data_in  = 36'h200;
        #1;
        total_cnt++; if (req_ready_out !== 1'b1 || resp_ready_out !== 1'b1) $display("FAIL sim_ready got %b%b exp 11", req_ready_out, resp_ready_out); else pass_cnt++;
        tick();
        req_valid_in  = 1'b0;
        resp_valid_in = 1'b0;
        #1;
        total_cnt++; if (outstanding_count !== 4'd3) $display("FAIL sim_count got %0d exp 3", outstanding_count); else pass_cnt++;
        total_cnt++; if (resp_tag_out !== 8'h31 || resp_data_out !== 36'h200) $display("FAIL sim_head got %h/%h exp 31/200", resp_tag_out, resp_data_out); else pass_cnt++;
    endtask

    task automatic test_orphan();
        do_reset();
        resp_valid_in = 1'b1;
        resp_data_in  = 36'h300;
        tick();
        resp_valid_in = 1'b0;
        #1;
        total_cnt++; if (resp_valid_out !== 1'b1) $display("FAIL or_valid got %b exp 1", resp_valid_out); else pass_cnt++;
        total_cnt++; if (resp_tag_out !== 8'h00 || resp_data_out !== 36'h300) $display("FAIL or_head got %h/%h exp 00/300", resp_tag_out, resp_data_out); else pass_cnt++;
        total_cnt++; if (orphan_err !== 1'b1) $display("FAIL or_err got %b exp 1", orphan_err); else pass_cnt++;
        total_cnt++; if (outstanding_count !== 4'd0) $display("FAIL or_count got %0d exp 0", outstanding_count); else pass_cnt++;
        tick();
        tick();
        total_cnt++; if (orphan_err !== 1'b1) $display("FAIL or_sticky got %b exp 1", orphan_err); else pass_cnt++;
        push_req(8'h41);
        total_cnt++; if (outstanding_count !== 4'd1) $display("FAIL or_no_underflow got %0d exp 1", outstanding_count); else pass_cnt++;
    endtask

    // Continues from the orphan scenario: one tag (0x41) held, orphan_err set.
    task automatic test_reset_mid_stream();
        push_req(8'h51);
        push_req(8'h52);
        push_req(8'h53);
        resp_ready_in = 1'b0;
        resp_valid_in = 1'b1;
        resp_data_in  = 36'h400;
        tick();
        resp_data_in  = 36'h401;
        tick();
        resp_valid_in = 1'b0;
        #1;
        total_cnt++; if (outstanding_count !== 4'd2) $display("FAIL rm_count2 got %0d exp 2", outstanding_count); else pass_cnt++;
        total_cnt++; if (resp_valid_out !== 1'b1 || resp_tag_out !== 8'h41) $display("FAIL rm_head got %b/%h exp 1/41", resp_valid_out, resp_tag_out); else pass_cnt++;
        rst          = 1'b1;
        req_ready_in = 1'b0;
        #1;
        total_cnt++; if (req_ready_out !== 1'b0) $display("FAIL rm_req_ready got %b exp 0", req_ready_out); else pass_cnt++;
        tick();
        rst           = 1'b0;
        req_ready_in  = 1'b1;
        resp_ready_in = 1'b1;
        #1;
        total_cnt++; if (resp_valid_out !== 1'b0) $display("FAIL rm_valid got %b exp 0", resp_valid_out); else pass_cnt++;
        total_cnt++; if (outstanding_count !== 4'd0) $display("FAIL rm_count0 got %0d exp 0", outstanding_count); else pass_cnt++;
        total_cnt++; if (orphan_err !== 1'b0) $display("FAIL rm_orphan got %b exp 0", orphan_err); else pass_cnt++;
        total_cnt++; if (resp_ready_out !== 1'b1) $display("FAIL rm_resp_ready got %b exp 1", resp_ready_out); else pass_cnt++;
        push_req(8'h61);
        resp_valid_in = 1'b1;
        resp_data_in  = 36'h500;
        tick();
        resp_valid_in = 1'b0;
        #1;
        total_cnt++; if (resp_valid_out !== 1'b1 || resp_tag_out !== 8'h61 || resp_data_out !== 36'h500)
            $display("FAIL rm_new got %b/%h/%h exp 1/61/500", resp_valid_out, resp_tag_out, resp_data_out);
        else pass_cnt++;
        total_cnt++; if (outstanding_count !== 4'd0) $display("FAIL rm_count_end got %0d exp 0", outstanding_count); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_tag_full();
        test_backpressure();
        test_simultaneous();
        test_orphan();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
